// File: rtl/switch_debouncer.sv
// switch_debouncer
//   Per-channel conditioning of raw switch / push-button inputs: a 2-flop
//   synchronizer followed by a stability counter. The debounced level SW_OUT
//   only follows the synchronized input after it has held a new value for
//   STABLE_CYCLES consecutive clocks. Any return to the current SW_OUT level
//   before the terminal count clears the counter, so short bounces never pass.
//
//   Optional feature macro: SWITCH_DEBOUNCER_EDGE_EN
//     defined   - registered one-cycle RISE/FALL pulses, coincident with the
//                 SW_OUT update that caused them.
//     undefined - RISE/FALL are tied low and no edge registers exist. The
//                 port list and SW_OUT behaviour are the same in both builds.
module switch_debouncer #(
  parameter int N_CH          = 2,
  parameter int STABLE_CYCLES = 1000000,
  parameter int CNT_W         = 20
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic [N_CH-1:0] SW_IN,
  output logic [N_CH-1:0] SW_OUT,
  output logic [N_CH-1:0] RISE,
  output logic [N_CH-1:0] FALL
);

  // Count value at which a pending change is accepted. The counter is
  // cleared at this value, so it never exceeds STABLE_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STABLE_CYCLES - 1);

  // Next counter value while the synchronized input differs from SW_OUT:
  // advance by one, or restart once the terminal count has been reached.
  function automatic logic [CNT_W-1:0] f_cnt_next(input logic [CNT_W-1:0] cnt);
    if (cnt == CNT_TERM) begin
      return '0;
    end
    return cnt + CNT_W'(1);
  endfunction

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic             r_sync_p0;
    logic             r_sync_p1;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out;
    logic             w_differ;
    logic             w_term;

    // The counter only runs while the synchronized level disagrees with the
    // debounced level; reaching the terminal value commits the new level.
    assign w_differ = (r_sync_p1 != r_out);
    assign w_term   = w_differ && (r_cnt == CNT_TERM);

    // Two-flop synchronizer for the asynchronous raw input.
    always_ff @(posedge CLOCK) begin
      if (RESET) begin
        r_sync_p0 <= 1'b0;
        r_sync_p1 <= 1'b0;
      end else begin
        r_sync_p0 <= SW_IN[gi];
        r_sync_p1 <= r_sync_p0;
      end
    end

    // Stability counter and debounced level; a partial count is dropped on reset.
    always_ff @(posedge CLOCK) begin
      if (RESET) begin
        r_cnt <= '0;
        r_out <= 1'b0;
      end else if (!w_differ) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= f_cnt_next(r_cnt);
        if (w_term) begin
          r_out <= r_sync_p1;
        end
      end
    end

    assign SW_OUT[gi] = r_out;

`ifdef SWITCH_DEBOUNCER_EDGE_EN
    logic r_rise;
    logic r_fall;

    // Edge pulses registered on the same edge that updates SW_OUT; the
    // direction is the level being committed, so RISE and FALL are exclusive.
    always_ff @(posedge CLOCK) begin
      if (RESET) begin
        r_rise <= 1'b0;
        r_fall <= 1'b0;
      end else begin
        r_rise <= w_term &&  r_sync_p1;
        r_fall <= w_term && !r_sync_p1;
      end
    end

    assign RISE[gi] = r_rise;
    assign FALL[gi] = r_fall;
`else
    assign RISE[gi] = 1'b0;
    assign FALL[gi] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer
//   Directed bench for switch_debouncer with STABLE_CYCLES=4, N_CH=2.
//   RISE/FALL expectations follow SWITCH_DEBOUNCER_EDGE_EN: pulses when the
//   macro is defined, constant zero otherwise; SW_OUT expectations are the same.
module tb_switch_debouncer;

  localparam int N_CH          = 2;
  localparam int STABLE_CYCLES = 4;
  localparam int CNT_W         = 3;

`ifdef SWITCH_DEBOUNCER_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic [N_CH-1:0] sw_in;
  logic [N_CH-1:0] sw_out;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;

  int checks   = 0;
  int failures = 0;

  logic [1:0] exp_out;
  logic [1:0] exp_rise;
  logic [1:0] exp_fall;

  switch_debouncer #(
    .N_CH          (N_CH),
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) dut (
    .CLOCK  (clk),
    .RESET  (rst),
    .SW_IN  (sw_in),
    .SW_OUT (sw_out),
    .RISE   (rise),
    .FALL   (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    sw_in = 2'b11;
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) sw_in = 2'b00;
      tick();
      checks++;
      if (sw_out !== 2'b00) begin
        failures++;
        $display("FAIL reset_out edge=%0d got=%b exp=00", k, sw_out);
      end
      checks++;
      if (rise !== 2'b00 || fall !== 2'b00) begin
        failures++;
        $display("FAIL reset_edges edge=%0d rise=%b fall=%b exp=00/00", k, rise, fall);
      end
    end
  endtask

  // Single-channel rise: new level appears at edge STABLE_CYCLES+2 = 6.
  task automatic test_rise_ch0();
    rst   = 1'b0;
    sw_in = 2'b01;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_out  = (k >= 6) ? 2'b01 : 2'b00;
      exp_rise = (EDGE_EN && k == 6) ? 2'b01 : 2'b00;
      exp_fall = 2'b00;
      checks++;
      if (sw_out !== exp_out) begin
        failures++;
        $display("FAIL rise_ch0_out edge=%0d got=%b exp=%b", k, sw_out, exp_out);
      end
      checks++;
      if (rise !== exp_rise) begin
        failures++;
        $display("FAIL rise_ch0_rise edge=%0d got=%b exp=%b", k, rise, exp_rise);
      end
      checks++;
      if (fall !== exp_fall) begin
        failures++;
        $display("FAIL rise_ch0_fall edge=%0d got=%b exp=%b", k, fall, exp_fall);
      end
    end
  endtask

  // Channel 1 bounces 1,0,1,0 in 2-cycle steps, then settles at 1.
  task automatic test_bounce_ch1();
    for (int b = 0; b < 4; b++) begin
      sw_in = (b % 2 == 0) ? 2'b11 : 2'b01;
      for (int k = 0; k < 2; k++) begin
        tick();
        checks++;
        if (sw_out !== 2'b01 || rise !== 2'b00 || fall !== 2'b00) begin
          failures++;
          $display("FAIL bounce_hold step=%0d out=%b rise=%b fall=%b exp=01/00/00",
                   b, sw_out, rise, fall);
        end
      end
    end
    sw_in = 2'b11;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_out  = (k >= 6) ? 2'b11 : 2'b01;
      exp_rise = (EDGE_EN && k == 6) ? 2'b10 : 2'b00;
      checks++;
      if (sw_out !== exp_out) begin
        failures++;
        $display("FAIL bounce_settle_out edge=%0d got=%b exp=%b", k, sw_out, exp_out);
      end
      checks++;
      if (rise !== exp_rise || fall !== 2'b00) begin
        failures++;
        $display("FAIL bounce_settle_edges edge=%0d rise=%b fall=%b exp=%b/00",
                 k, rise, fall, exp_rise);
      end
    end
  endtask

  // Both channels fall together and commit on the same edge.
  task automatic test_both_fall();
    sw_in = 2'b00;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_out  = (k >= 6) ? 2'b00 : 2'b11;
      exp_fall = (EDGE_EN && k == 6) ? 2'b11 : 2'b00;
      checks++;
      if (sw_out !== exp_out) begin
        failures++;
        $display("FAIL both_fall_out edge=%0d got=%b exp=%b", k, sw_out, exp_out);
      end
      checks++;
      if (fall !== exp_fall) begin
        failures++;
        $display("FAIL both_fall_fall edge=%0d got=%b exp=%b", k, fall, exp_fall);
      end
      checks++;
      if (rise !== 2'b00) begin
        failures++;
        $display("FAIL both_fall_rise edge=%0d got=%b exp=00", k, rise);
      end
    end
  endtask

  // Reset mid-count discards progress; counting restarts after release.
  task automatic test_reset_mid_count();
    sw_in = 2'b01;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (sw_out !== 2'b00) begin
        failures++;
        $display("FAIL midrst_pre edge=%0d got=%b exp=00", k, sw_out);
      end
    end
    rst = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      tick();
      checks++;
      if (sw_out !== 2'b00 || rise !== 2'b00 || fall !== 2'b00) begin
        failures++;
        $display("FAIL midrst_during edge=%0d out=%b rise=%b fall=%b exp=00/00/00",
                 k, sw_out, rise, fall);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_out  = (k >= 6) ? 2'b01 : 2'b00;
      exp_rise = (EDGE_EN && k == 6) ? 2'b01 : 2'b00;
      checks++;
      if (sw_out !== exp_out) begin
        failures++;
        $display("FAIL midrst_after_out edge=%0d got=%b exp=%b", k, sw_out, exp_out);
      end
      checks++;
      if (rise !== exp_rise || fall !== 2'b00) begin
        failures++;
        $display("FAIL midrst_after_edges edge=%0d rise=%b fall=%b exp=%b/00",
                 k, rise, fall, exp_rise);
      end
    end
  endtask

  // A 3-cycle glitch (one short of the threshold) is rejected; a 4-cycle
  // one is accepted, then the level returns 4 cycles after that.
  task automatic test_glitch_boundary();
    sw_in = 2'b00;
    for (int k = 1; k <= 3; k++) tick();
    sw_in = 2'b01;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (sw_out !== 2'b01 || fall !== 2'b00) begin
        failures++;
        $display("FAIL glitch3 edge=%0d out=%b fall=%b exp=01/00", k, sw_out, fall);
      end
    end
    for (int k = 1; k <= 12; k++) begin
      if (k == 1) sw_in = 2'b00;
      if (k == 5) sw_in = 2'b01;
      tick();
      exp_out  = (k >= 6 && k <= 9) ? 2'b00 : 2'b01;
      exp_fall = (EDGE_EN && k == 6)  ? 2'b01 : 2'b00;
      exp_rise = (EDGE_EN && k == 10) ? 2'b01 : 2'b00;
      checks++;
      if (sw_out !== exp_out) begin
        failures++;
        $display("FAIL glitch4_out edge=%0d got=%b exp=%b", k, sw_out, exp_out);
      end
      checks++;
      if (rise !== exp_rise || fall !== exp_fall) begin
        failures++;
        $display("FAIL glitch4_edges edge=%0d rise=%b fall=%b exp=%b/%b",
                 k, rise, fall, exp_rise, exp_fall);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    sw_in = 2'b00;
    test_reset();
    test_rise_ch0();
    test_bounce_ch1();
    test_both_fall();
    test_reset_mid_count();
    test_glitch_boundary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
